// File: rtl/ecc72_pkg.sv
`default_nettype none
// ecc72_pkg: extended Hamming (72,64) position map, syndrome lookup and classification types.
// Revision 1.0
package ecc72_pkg;

  localparam int DATA_W = 64;
  localparam int CHK_W  = 7;
  localparam int PAR_W  = 1;
  localparam int SYN_W  = CHK_W + PAR_W;
  localparam int CW_W   = 72;

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    CORR   = 2'd1,
    UNCORR = 2'd2
  } cls_t;

  typedef logic [DATA_W-1:0][CHK_W-1:0] pos_map_t;

  typedef struct packed {
    logic       hit;
    logic [5:0] idx;
  } dpos_t;

  // Data bit n occupies the n-th non-power-of-two Hamming position from 3 upward.
  function automatic pos_map_t build_pos_map();
    pos_map_t m;
    int       n;
    m = '0;
    n = 0;
    for (int p = 3; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        m[6'(n)] = CHK_W'(p);
        n++;
      end
    end
    return m;
  endfunction

  localparam pos_map_t POS_MAP = build_pos_map();

  function automatic dpos_t syn_to_idx(input logic [CHK_W-1:0] s);
    dpos_t r;
    r = '0;
    for (int j = 0; j < DATA_W; j++) begin
      if (POS_MAP[6'(j)] == s) begin
        r.hit = 1'b1;
        r.idx = 6'(j);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecc72_syndrome.sv
`default_nettype none
// ecc72_syndrome: combinational syndrome and overall parity of a 72-bit codeword.
// With check bits and P zeroed on the input, syn yields the check bits an encoder must emit.
module ecc72_syndrome
  import ecc72_pkg::*;
(
  input  logic [CW_W-1:0]  cw,
  output logic [CHK_W-1:0] syn,
  output logic             par
);

  always_comb begin
    syn = cw[DATA_W +: CHK_W];
    for (int j = 0; j < DATA_W; j++) begin
      if (cw[7'(j)]) syn = syn ^ POS_MAP[6'(j)];
    end
    par = ^cw;
  end

endmodule
`default_nettype wire

// File: rtl/ecc72_decode_pipe.sv
`default_nettype none
// ecc72_decode_pipe: two-stage SECDED (72,64) decoder with valid/ready flow control and
// saturating corrected/uncorrectable event counters. Revision 1.0
module ecc72_decode_pipe
  import ecc72_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr,
  output logic [SYN_W-1:0]  out_syn,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  logic              adv;
  logic              fire;
  logic [CHK_W-1:0]  syn_in;
  logic              par_in;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [CHK_W-1:0]  s1_syn;
  logic              s1_par;
  cls_t              cls;
  dpos_t             dpos;
  logic [DATA_W-1:0] fixed;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  assign fire     = out_valid && out_ready;

  ecc72_syndrome u_syndrome (
    .cw  (in_data),
    .syn (syn_in),
    .par (par_in)
  );

  // Stage 1: only the data part of the codeword is kept; check bits live on in the syndrome.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data[DATA_W-1:0];
        s1_syn  <= syn_in;
        s1_par  <= par_in;
      end
    end
  end

  always_comb begin
    fixed = s1_data;
    dpos  = syn_to_idx(s1_syn);
    if (!s1_par) begin
      cls = (s1_syn == '0) ? CLEAN : UNCORR;
    end else if ((s1_syn & (s1_syn - CHK_W'(1))) == '0) begin
      // Zero or power-of-two syndrome: P or a check bit flipped, data is intact.
      cls = CORR;
    end else if (dpos.hit) begin
      cls = CORR;
      if (CORRECT_EN) fixed[dpos.idx] = ~fixed[dpos.idx];
    end else begin
      cls = UNCORR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_syn    <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (adv) begin
      out_valid  <= s1_valid;
      out_data   <= fixed;
      out_syn    <= {s1_par, s1_syn};
      out_corr   <= s1_valid && (cls == CORR);
      out_uncorr <= s1_valid && (cls == UNCORR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (fire) begin
      if (out_corr && !(&cnt_corr))     cnt_corr   <= cnt_corr + CNT_W'(1);
      if (out_uncorr && !(&cnt_uncorr)) cnt_uncorr <= cnt_uncorr + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ecc72_decode_pipe.sv
`default_nettype none
// tb_ecc72_decode_pipe: directed and random stimulus against a position-XOR reference model.
module tb_ecc72_decode_pipe;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [63:0] GOLD = 64'h0123_4567_89AB_CDEF;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready;
  logic             out_corr, out_uncorr, cnt_clr;
  logic [71:0]      in_data;
  logic [63:0]      out_data;
  logic [7:0]       out_syn;
  logic [CNT_W-1:0] cnt_corr, cnt_uncorr;

  always #5 clk = ~clk;

  ecc72_decode_pipe #(.CNT_W(CNT_W), .CORRECT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_corr(out_corr),
    .out_uncorr(out_uncorr), .out_syn(out_syn), .cnt_clr(cnt_clr), .cnt_corr(cnt_corr),
    .cnt_uncorr(cnt_uncorr)
  );

  typedef struct {
    logic [63:0] data;
    logic        corr;
    logic        uncorr;
    logic [7:0]  syn;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          pos_tab[72];
  int          total = 0, bad = 0, cyc = 0, last_stall = -1;
  int          m_cc = 0, m_cu = 0;
  logic        prev_rst = 1'b0, prev_hold = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_syn;
  logic        prev_c, prev_u;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Syndrome of any codeword = XOR of the Hamming positions of its set bits.
  function automatic logic [71:0] enc(input logic [63:0] d);
    logic [71:0] cw;
    int s;
    s  = 0;
    cw = {8'h00, d};
    for (int b = 0; b < 64; b++) if (d[b]) s ^= pos_tab[b];
    for (int i = 0; i < 7; i++) cw[64+i] = s[i];
    cw[71] = ^cw[70:0];
    return cw;
  endfunction

  function automatic logic [71:0] flip(input logic [71:0] cw, input int a);
    cw[a] = ~cw[a];
    return cw;
  endfunction

  function automatic exp_t model(input logic [71:0] raw);
    exp_t e;
    int   s;
    logic p;
    s = 0;
    for (int b = 0; b < 71; b++) if (raw[b]) s ^= pos_tab[b];
    p        = ^raw;
    e.data   = raw[63:0];
    e.corr   = 1'b0;
    e.uncorr = 1'b0;
    e.syn    = {p, 7'(s)};
    e.acc    = 0;
    if (!p) e.uncorr = (s != 0);
    else if (s == 0 || (s & (s - 1)) == 0) e.corr = 1'b1;
    else if (s <= 71) begin
      e.corr = 1'b1;
      for (int j = 0; j < 64; j++) if (pos_tab[j] == s) e.data[j] = ~e.data[j];
    end else e.uncorr = 1'b1;
    return e;
  endfunction

  function automatic logic [71:0] rand_word(input int nflip);
    logic [71:0] cw;
    cw = enc({$urandom, $urandom});
    for (int k = 0; k < nflip; k++) cw = flip(cw, $urandom_range(0, 71));
    return cw;
  endfunction

  task automatic cycle(input logic v, input logic [71:0] d, input logic ordy,
                       input logic clr, input logic r);
    logic exp_rdy, fire, acc;
    exp_t e;
    rst = r; in_valid = v; in_data = d; out_ready = ordy; cnt_clr = clr;
    #2;
    exp_rdy = !r && (out_valid !== 1'b1 || ordy);
    chk("in_ready", in_ready, exp_rdy);
    if (prev_rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_syn", out_syn, 0);
      chk("rst_out_corr", out_corr, 0);
      chk("rst_out_uncorr", out_uncorr, 0);
    end else begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_syn", out_syn, prev_syn);
        chk("hold_flags", {out_corr, out_uncorr}, {prev_c, prev_u});
      end
      if (out_valid === 1'b1) begin
        if (q.size() == 0) chk("unexpected_word", out_valid, 0);
        else begin
          chk("out_data", out_data, q[0].data);
          chk("out_syn", out_syn, q[0].syn);
          chk("out_corr", out_corr, q[0].corr);
          chk("out_uncorr", out_uncorr, q[0].uncorr);
          if (q[0].acc > last_stall) chk("latency", cyc - q[0].acc, 2);
        end
      end else begin
        chk("idle_valid", out_valid, 0);
        chk("idle_flags", {out_corr, out_uncorr}, 2'b00);
        if (q.size() != 0 && q[0].acc > last_stall && cyc >= q[0].acc + 2)
          chk("bubble", out_valid, 1);
      end
    end
    chk("cnt_corr", cnt_corr, m_cc);
    chk("cnt_uncorr", cnt_uncorr, m_cu);
    fire      = !r && out_valid === 1'b1 && ordy;
    acc       = v && exp_rdy;
    prev_hold = !r && out_valid === 1'b1 && !ordy;
    prev_data = out_data; prev_syn = out_syn; prev_c = out_corr; prev_u = out_uncorr;
    if (!ordy) last_stall = cyc;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_cc = 0;
      m_cu = 0;
    end else begin
      if (fire && q.size() > 0) begin
        e = q.pop_front();
        if (e.corr)   m_cc = (m_cc == CMAX) ? CMAX : m_cc + 1;
        if (e.uncorr) m_cu = (m_cu == CMAX) ? CMAX : m_cu + 1;
      end
      if (clr) begin
        m_cc = 0;
        m_cu = 0;
      end
      if (acc) begin
        e     = model(d);
        e.acc = cyc;
        q.push_back(e);
      end
    end
    prev_rst = r;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    n = 0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) == 0) pos_tab[64 + $clog2(p)] = p;
      else begin
        pos_tab[n] = p;
        n++;
      end
    end
    pos_tab[71] = 0;

    // Reset held with in_valid asserted.
    rst = 1'b1; in_valid = 1'b1; in_data = enc(GOLD); out_ready = 1'b1; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    prev_rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b1, enc(GOLD), 1'b1, 1'b0, 1'b1);

    // Clean back-to-back stream.
    for (int i = 0; i < 8; i++) cycle(1'b1, enc(GOLD), 1'b1, 1'b0, 1'b0);
    idle(3);

    // Single-bit errors: data bit 17, check bit C3, overall parity P.
    cycle(1'b1, flip(enc(GOLD), 17), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, flip(enc(GOLD), 67), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, flip(enc(GOLD), 71), 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("cnt_corr_after_singles", cnt_corr, 3);

    // Double error: data bits 0 and 63.
    cycle(1'b1, flip(flip(enc(GOLD), 0), 63), 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("cnt_uncorr_after_double", cnt_uncorr, 1);

    // Backpressure: out_ready low for 5 cycles mid-stream.
    for (int i = 0; i < 14; i++)
      cycle(1'b1, rand_word($urandom_range(0, 2)), !(i >= 4 && i < 9), 1'b0, 1'b0);
    idle(4);
    chk("drained_after_stall", q.size(), 0);

    // Random traffic, including occasional counter clears and triple flips.
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 3) != 0, rand_word($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, 1'b0);
    idle(4);
    chk("drained_after_random", q.size(), 0);

    // Counter saturation at 15, then clear coinciding with an increment.
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, rand_word(1), 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("cnt_corr_saturated", cnt_corr, CMAX);
    cycle(1'b1, flip(enc(GOLD), 5), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("clr_beats_increment", cnt_corr, 0);
    idle(2);

    // Mid-stream reset discards in-flight words; next word emerges 2 cycles later.
    cycle(1'b1, flip(enc(GOLD), 9), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, flip(flip(enc(GOLD), 2), 3), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, enc(GOLD), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, enc(GOLD), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, flip(enc(GOLD), 40), 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("cnt_corr_after_reset", cnt_corr, 1);
    chk("cnt_uncorr_after_reset", cnt_uncorr, 0);
    chk("drained_final", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ecc72_decode_pipe.md
ECC72_DECODE_PIPE -- requirements
Module: ecc72_decode_pipe

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating error counters.
REQ-002 Parameter CORRECT_EN, default 1, 1 = flip the single-bit error, 0 = detect and flag only.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  codeword present on in_data.
REQ-006 in_ready  out  1  block accepts in_data this cycle.
REQ-007 in_data  in  72  codeword: [63:0] data, [70:64] Hamming check C6..C0, [71] overall parity P.
REQ-008 out_valid  out  1  decoded word present.
REQ-009 out_ready  in  1  downstream accepts the word.
REQ-010 out_data  out  64  corrected data.
REQ-011 out_corr  out  1  single-bit error was corrected (or flagged, if CORRECT_EN=0).
REQ-012 out_uncorr  out  1  uncorrectable error; out_data is the raw, uncorrected data.
REQ-013 out_syn  out  8  {overall-parity mismatch, 7-bit syndrome} for the word.
REQ-014 cnt_clr  in  1  synchronous clear of both counters.
REQ-015 cnt_corr, cnt_uncorr  out  CNT_W each  saturating event counts.

Function
REQ-016 The code shall be extended Hamming (72,64), with the bit-position map defined in the package; it shall match the encoder bit for bit.
  - Position map: check bit Ci sits at Hamming position 2^i; data bits fill the non-power-of-two positions 3..71 in ascending order; P covers all 72 bits.
REQ-017 Stage 1 shall register the raw codeword, the syndrome s = recomputed check XOR received check, and p = XOR of all 72 bits.
REQ-018 Stage 2 shall classify, correct and register the outputs.
  - s=0, p=0: clean.
  - p=1, s=0: P bit in error; corr=1, data unchanged.
  - p=1, s is a power of two: check bit in error; corr=1, data unchanged.
  - p=1, s is a valid data position: flip that data bit; corr=1.
  - p=1, s>71: uncorr=1.
  - s!=0, p=0: double error; uncorr=1.
REQ-019 Latency shall be exactly 2 cycles, in_valid&in_ready to out_valid, when out_ready is held high.
REQ-020 Pipeline enable shall be adv = !out_valid | out_ready.
  - in_ready = adv (combinational).
  - Both stages shall hold all contents when adv=0.
REQ-021 Throughput shall be one word per cycle when out_ready is held high; no bubbles shall be inserted.
REQ-022 Outputs shall remain stable while out_valid=1 and out_ready=0.
REQ-023 A stage valid bit shall clear on advance when its upstream stage was empty.
REQ-024 out_corr and out_uncorr shall be mutually exclusive and 0 whenever out_valid=0.
REQ-025 Counters shall increment once per accepted output word (out_valid&out_ready) carrying the matching flag.
  - Counters saturate at 2^CNT_W-1.
  - When cnt_clr and an increment coincide, the counter shall load 0 (clear wins).

Reset
REQ-026 While rst=1, the block shall clear all stage valid bits and force out_valid=0 and both counters to 0.
REQ-027 While rst=1, out_data, out_syn, out_corr and out_uncorr shall be 0; in_ready shall be 0.
REQ-028 When reset is asserted mid-stream, in-flight words shall be discarded without counting; the first word accepted after rst falls shall emerge 2 cycles later.

Structure
REQ-029 Package ecc72_pkg shall hold the position map table, syndrome-to-data-index lookup, check-bit widths (7+1) and classification enum {CLEAN, CORR, UNCORR}.
REQ-030 One sub-module ecc72_syndrome shall exist: combinational syndrome and parity computation, reused by the matching encoder.

Verification
REQ-031 Reset check: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, counters 0 throughout.
REQ-032 Clean stream: encode 0x0123_4567_89AB_CDEF, send back-to-back 8 words with out_ready=1 -> outputs appear at cycle+2 with no bubbles, corr=uncorr=0.
REQ-033 Single-bit errors: flip data bit 17, then check bit C3, then P -> data 0x0123_4567_89AB_CDEF each time, corr=1, cnt_corr=3.
REQ-034 Double error: flip data bits 0 and 63 -> uncorr=1, out_data equals the raw corrupted data, cnt_uncorr increments by 1.
REQ-035 Backpressure: drop out_ready for 5 cycles mid-stream -> in_ready low, out_data stable, no word lost or duplicated; counters count each word once.
REQ-036 Counter edge: CNT_W=4, 20 corrected words -> cnt_corr saturates at 15; cnt_clr coincident with an increment -> 0.
